// File: rtl/ofm_stream_checker.sv
// rtl/ofm_stream_checker.sv - CONV output-feature-map stream checker against a golden memory
//
// Watches the CONV output stream and compares the last beat of every element
// against a golden word fetched through gold_addr (one-cycle synchronous read).
//
// Ports:
//   clk1, rst_n                  clock (rising edge), asynchronous active-low reset
//   start                        arm/restart pulse; clears all results and enters RUN
//   out_valid, data_output       CONV output beats, REPEAT beats per element
//   end_conv                     CONV end indication; early end flags underrun
//   gold_addr, gold_data         golden memory address (= element counter) and read data
//   busy, done, pass             RUN status, finished level, verdict (valid with done)
//   mismatch_cnt, first_err_idx  saturating mismatch count, index of first mismatch
//   err_seen, underrun, overrun  mismatch seen, early end_conv, beat received while DONE
//
// Optional feature macro OFM_CHK_TOL_EN: compare within absolute tolerance TOL
// using a DATA_WIDTH+1 bit signed difference instead of bitwise equality.
module ofm_stream_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int OFM_SIZE   = 16,
    parameter int CO         = 2,
    parameter int REPEAT     = 2,
    parameter int IDX_W      = 16,
    parameter int CNT_W      = 16,
    parameter int TOL        = 0
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  out_valid,
    input  logic [DATA_WIDTH-1:0] data_output,
    input  logic                  end_conv,
    output logic [IDX_W-1:0]      gold_addr,
    input  logic [DATA_WIDTH-1:0] gold_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [IDX_W-1:0]      first_err_idx,
    output logic                  err_seen,
    output logic                  underrun,
    output logic                  overrun
);
    localparam int               TOTAL     = OFM_SIZE * OFM_SIZE * CO;
    localparam int               BW        = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [BW-1:0]    BEAT_LAST = BW'(REPEAT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state_q;
    logic [BW-1:0]           beat_cnt_q;
    logic [IDX_W-1:0]        elem_cnt_q;
    logic                    all_acc_q;   // final element captured, waiting for its compare
    logic                    end_pend_q;  // early end_conv seen while a compare was in flight
    logic                    s1_valid_q;
    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic [IDX_W-1:0]        s1_idx_q;
    logic [CNT_W-1:0]        mismatch_cnt_q;
    logic [IDX_W-1:0]        first_err_idx_q;
    logic                    err_seen_q;
    logic                    underrun_q;
    logic                    overrun_q;
    logic                    done_q;
    logic                    pass_q;

    logic beat_ok, elem_acc, final_acc, s1_last, underrun_now, mis, err_d;

    // start wins over a simultaneous beat; no beats are taken once the stream is complete
    assign beat_ok      = (state_q == S_RUN) && out_valid && !start && !all_acc_q && !end_pend_q;
    assign elem_acc     = beat_ok && (beat_cnt_q == BEAT_LAST);
    assign final_acc    = elem_acc && (elem_cnt_q == LAST_IDX);
    assign s1_last      = s1_valid_q && (s1_idx_q == LAST_IDX);
    // end_conv together with the final element's beat is a normal completion
    assign underrun_now = (state_q == S_RUN) && !start && end_conv && !end_pend_q
                          && !all_acc_q && !final_acc;
    assign err_d        = err_seen_q || (s1_valid_q && mis);

`ifdef OFM_CHK_TOL_EN
    logic signed [DATA_WIDTH:0] diff;
    logic        [DATA_WIDTH:0] mag;
    assign diff = $signed({s1_data_q[DATA_WIDTH-1], s1_data_q})
                - $signed({gold_data[DATA_WIDTH-1], gold_data});
    assign mag  = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign mis  = mag > (DATA_WIDTH+1)'(TOL);
`else
    logic unused_tol;
    assign unused_tol = ^TOL;
    assign mis        = s1_data_q != gold_data;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            beat_cnt_q      <= '0;
            elem_cnt_q      <= '0;
            all_acc_q       <= 1'b0;
            end_pend_q      <= 1'b0;
            s1_valid_q      <= 1'b0;
            s1_data_q       <= '0;
            s1_idx_q        <= '0;
            mismatch_cnt_q  <= '0;
            first_err_idx_q <= '0;
            err_seen_q      <= 1'b0;
            underrun_q      <= 1'b0;
            overrun_q       <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else if (start) begin
            state_q         <= S_RUN;
            beat_cnt_q      <= '0;
            elem_cnt_q      <= '0;
            all_acc_q       <= 1'b0;
            end_pend_q      <= 1'b0;
            s1_valid_q      <= 1'b0;
            mismatch_cnt_q  <= '0;
            first_err_idx_q <= '0;
            err_seen_q      <= 1'b0;
            underrun_q      <= 1'b0;
            overrun_q       <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (beat_ok) begin
                        beat_cnt_q <= (beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + 1'b1;
                    end
                    s1_valid_q <= elem_acc;
                    if (elem_acc) begin
                        s1_data_q  <= data_output;
                        s1_idx_q   <= elem_cnt_q;
                        elem_cnt_q <= elem_cnt_q + 1'b1;
                    end
                    if (final_acc) begin
                        all_acc_q <= 1'b1;
                    end
                    if (s1_valid_q && mis) begin
                        if (mismatch_cnt_q != {CNT_W{1'b1}}) begin
                            mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
                        end
                        if (!err_seen_q) begin
                            first_err_idx_q <= s1_idx_q;
                        end
                        err_seen_q <= 1'b1;
                    end
                    // Finish on the final compare, or on early end once nothing is in flight
                    if (s1_last || end_pend_q || (underrun_now && !elem_acc)) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        underrun_q <= underrun_now || end_pend_q;
                        pass_q     <= !err_d && !(underrun_now || end_pend_q);
                        end_pend_q <= 1'b0;
                    end else if (underrun_now) begin
                        end_pend_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_valid) begin
                        overrun_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gold_addr     = elem_cnt_q;
    assign busy          = (state_q == S_RUN);
    assign done          = done_q;
    assign pass          = pass_q;
    assign mismatch_cnt  = mismatch_cnt_q;
    assign first_err_idx = first_err_idx_q;
    assign err_seen      = err_seen_q;
    assign underrun      = underrun_q;
    assign overrun       = overrun_q;
endmodule
